instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 30 +++
 rtl/instr_fetch_branch_target.sv | 35 +++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared types and constants for the instruction fetch stage:
//               FSM state encoding, branch immediate field positions and the
//               default instruction memory size.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

  // Fetch FSM state, encoded as plain constants for legacy tool compatibility
  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t RUN  = 1'b0;
  localparam fetch_state_t HALT = 1'b1;

  // B-type immediate: imm26 = instr[25:0]
  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM26_W   = IMM26_MSB - IMM26_LSB + 1;

  // CB-type immediate: imm19 = instr[23:5]
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;
  localparam int IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

  // Default instruction memory size in bytes
  localparam int unsigned DEFAULT_MEM_SIZE = 1024;

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_branch_target.sv
`default_nettype none
// ============================================================================
// Module      : branch_target
// Description : Combinational branch target calculator. Selects the imm26 or
//               imm19 field, sign-extends it, scales it to a byte offset and
//               adds it to the PC of the branch (64-bit, wraps silently).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target
  import instr_fetch_pkg::*;
(
  input  logic [63:0] pc,
  input  logic [31:0] instr,
  input  logic        uncond,
  output logic [63:0] target
);

  logic [63:0] w_offset;
  // Opcode bits are not part of either immediate
  logic        w_unused_opcode;

  assign w_unused_opcode = ^instr[31:IMM26_MSB+1];

  // Sign-extend the selected immediate, shift left by 2 and add to the PC
  always_comb begin
    if (uncond) begin
      w_offset = {{(64-IMM26_W-2){instr[IMM26_MSB]}}, instr[IMM26_MSB:IMM26_LSB], 2'b00};
    end else begin
      w_offset = {{(64-IMM19_W-2){instr[IMM19_MSB]}}, instr[IMM19_MSB:IMM19_LSB], 2'b00};
    end
    target = pc + w_offset;
  end

endmodule : branch_target
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Single-entry instruction fetch stage. Registers one
//               instruction word with its PC, honours consumer backpressure,
//               redirects on taken branches (one bubble) and halts once the
//               PC runs past the end of instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] address,
  input  logic [31:0] instruction,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [63:0] fetch_pc,
  input  logic        dec_ready,
  input  logic        br_taken,
  input  logic        br_uncond,
  output logic        halted
);

  localparam logic [64:0] C_MEM_SIZE = 65'(MEM_SIZE);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [63:0]  r_pc;
  logic [63:0]  w_pc_nxt;
  logic         r_valid;
  logic         w_valid_nxt;
  logic [31:0]  r_instr;
  logic [63:0]  r_fetch_pc;
  logic [63:0]  w_target;
  logic         w_in_range;
  logic         w_nxt_in_range;
  logic         w_accept;
  logic         w_redirect;
  logic         w_capture;

  branch_target u_branch_target (
    .pc     (r_fetch_pc),
    .instr  (r_instr),
    .uncond (br_uncond),
    .target (w_target)
  );

  // Range checks are done 65 bits wide so PC+3 never wraps into range
  assign w_in_range     = ({1'b0, r_pc} + 65'd3) < C_MEM_SIZE;
  assign w_nxt_in_range = ({1'b0, w_pc_nxt} + 65'd3) < C_MEM_SIZE;

  assign w_accept   = r_valid & dec_ready;
  assign w_redirect = w_accept & br_taken;
  assign w_capture  = (r_state == RUN) & w_in_range & (~r_valid | w_accept) & ~w_redirect;

  // Next PC / valid / state: redirect wins over capture, plain accept drains
  always_comb begin
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_state_nxt = r_state;
    if (r_state == RUN) begin
      if (w_redirect) begin
        w_pc_nxt    = w_target;
        w_valid_nxt = 1'b0;
      end else if (w_capture) begin
        w_pc_nxt    = r_pc + 64'd4;
        w_valid_nxt = 1'b1;
      end else if (w_accept) begin
        w_valid_nxt = 1'b0;
      end
      if (!w_valid_nxt && !w_nxt_in_range) begin
        w_state_nxt = HALT;
      end
    end else begin
      w_valid_nxt = 1'b0;
    end
  end

  // Fetch state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= 32'd0;
      r_fetch_pc <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      if (w_capture) begin
        r_instr    <= instruction;
        r_fetch_pc <= r_pc;
      end
    end
  end

  assign address     = r_pc;
  assign fetch_valid = r_valid;
  assign fetch_instr = r_instr;
  assign fetch_pc    = r_fetch_pc;
  assign halted      = (r_state == HALT);

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard testbench for instr_fetch. The driver pushes the
//               expected (pc, instr) of every cycle it accepts; a negedge
//               monitor pops and compares on every accept.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        br_uncond = 1'b0;
  logic [63:0] address;
  logic [31:0] instruction;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [63:0] fetch_pc;
  logic        halted;

  logic [31:0] mem [256];
  int          vectors = 0;
  int          errors = 0;
  logic [95:0] sb [$];
  logic [95:0] mon_e;

  instr_fetch #(.MEM_SIZE(1024), .RESET_PC(64'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .instruction (instruction),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .dec_ready   (dec_ready),
    .br_taken    (br_taken),
    .br_uncond   (br_uncond),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Combinational memory model; out-of-range reads return zero
  assign instruction = (address < 64'd1024) ? mem[address[9:2]] : 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && fetch_valid && dec_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_accept: got pc %h expected none", fetch_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("accept_pc", fetch_pc, mon_e[95:32]);
        chk("accept_instr", {32'd0, fetch_instr}, {32'd0, mon_e[31:0]});
      end
    end
  end

  // One cycle of stimulus, starting and ending 1 time unit after a rising edge
  task automatic cyc(input logic rdy, input logic tk, input logic un, input logic ev,
                     input logic [63:0] epc, input logic [63:0] eaddr, input logic ehalt);
    dec_ready = rdy;
    br_taken  = tk;
    br_uncond = un;
    chk("valid", {63'd0, fetch_valid}, {63'd0, ev});
    chk("address", address, eaddr);
    chk("halted", {63'd0, halted}, {63'd0, ehalt});
    if (ev && !rdy) begin
      chk("stall_pc", fetch_pc, epc);
      chk("stall_instr", {32'd0, fetch_instr}, {32'd0, mem[epc[9:2]]});
    end
    if (ev && rdy) sb.push_back({epc, mem[epc[9:2]]});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {63'd0, fetch_valid}, 64'd0);
    chk({tag, "_pc"}, fetch_pc, 64'd0);
    chk({tag, "_instr"}, {32'd0, fetch_instr}, 64'd0);
    chk({tag, "_halted"}, {63'd0, halted}, 64'd0);
    chk({tag, "_address"}, address, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[2] = 32'h17FF_FFFE;   // imm26 = 0x3FFFFFE (-2)
    mem[4] = 32'hB400_0061;   // imm19 = 3

    #2;
    chk_reset_vals("por");
    @(posedge clk); #1;
    reset = 1'b0;
    dec_ready = 1'b1;
    @(posedge clk); #1;

    // Sequential fetch with a 3-cycle stall at pc 4
    cyc(1, 0, 0, 1, 64'h0, 64'h4, 0);
    cyc(0, 0, 0, 1, 64'h4, 64'h8, 0);
    cyc(0, 1, 1, 1, 64'h4, 64'h8, 0);
    cyc(0, 0, 0, 1, 64'h4, 64'h8, 0);
    cyc(1, 0, 0, 1, 64'h4, 64'h8, 0);
    // Unconditional branch back to 0; taken during the bubble is ignored
    cyc(1, 1, 1, 1, 64'h8, 64'hC, 0);
    cyc(1, 1, 1, 0, 64'h0, 64'h0, 0);
    cyc(1, 0, 0, 1, 64'h0, 64'h4, 0);
    cyc(1, 0, 0, 1, 64'h4, 64'h8, 0);
    cyc(1, 0, 0, 1, 64'h8, 64'hC, 0);
    cyc(1, 0, 0, 1, 64'hC, 64'h10, 0);
    // Conditional taken branch at 0x10 to 0x1C
    cyc(1, 1, 0, 1, 64'h10, 64'h14, 0);
    cyc(1, 0, 0, 0, 64'h0, 64'h1C, 0);
    cyc(1, 0, 0, 1, 64'h1C, 64'h20, 0);

    // Asynchronous reset between edges during a stall
    dec_ready = 1'b0;
    br_taken  = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    @(posedge clk); #1;
    reset = 1'b0;
    br_taken = 1'b0;
    dec_ready = 1'b1;
    @(posedge clk); #1;

    // Same conditional branch, not taken: no bubble
    cyc(1, 0, 0, 1, 64'h0, 64'h4, 0);
    cyc(1, 0, 0, 1, 64'h4, 64'h8, 0);
    cyc(1, 0, 0, 1, 64'h8, 64'hC, 0);
    cyc(1, 0, 0, 1, 64'hC, 64'h10, 0);
    cyc(1, 0, 1, 1, 64'h10, 64'h14, 0);
    // Run to the end of memory
    for (int p = 'h14; p <= 1020; p += 4) begin
      cyc(1, 0, 0, 1, 64'(p), 64'(p + 4), 0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 1, 0, 64'h0, 64'd1024, 1);
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire
